cpu_trace_buffer: RTL

- Parametrised on-chip commit-trace buffer for the MIPS_Processor core.
- Captures one record per retired instruction: PC, instruction word, register write-back and store flag.
- Supports fill-to-full or circular capture with a PC-match trigger and a post-trigger window.
- After capture stops, records are drained through a valid/ready port. This replaces per-cycle $display monitoring with a synthesizable, readable history.

---
 rtl/cpu_trace_buffer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: on-chip commit-trace buffer for the MIPS_Processor core.
// Records one entry per retired instruction (PC, instruction, register
// write-back, store flag). Capture runs either until the buffer fills (FILL)
// or circularly until a PC trigger plus a post-trigger window (RING). Once
// capture stops, the held records drain oldest-first through a valid/ready port.
module cpu_trace_buffer #(
  parameter int PC_W      = 32,
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               valid_in,
  input  logic [PC_W-1:0]                    pc_in,
  input  logic [DATA_W-1:0]                  instr_in,
  input  logic                               rf_we_in,
  input  logic [REG_AW-1:0]                  rf_waddr_in,
  input  logic [DATA_W-1:0]                  rf_wdata_in,
  input  logic                               mem_we_in,
  input  logic                               arm,
  input  logic                               mode,
  input  logic                               trig_en,
  input  logic [PC_W-1:0]                    trig_pc,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [PC_W+2*DATA_W+REG_AW+1:0]    rd_data,
  output logic [$clog2(DEPTH):0]             count,
  output logic [1:0]                         state,
  output logic                               triggered,
  output logic                               overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int REC_W = PC_W + 2*DATA_W + REG_AW + 2;

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT  = CW'(DEPTH - 1);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_CAPTURE = 2'b01,
    S_POST    = 2'b10,
    S_DONE    = 2'b11
  } state_t;

  typedef enum logic {
    M_FILL = 1'b0,
    M_RING = 1'b1
  } mode_t;

  state_t            state_q;
  mode_t             mode_q;
  logic              trig_en_q;
  logic [PC_W-1:0]   trig_pc_q;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic [AW-1:0]     post_cnt;
  logic              triggered_q;
  logic              overflow_q;

  logic [REC_W-1:0]  mem [DEPTH];

  logic              capturing;
  logic              wr_en;
  logic              at_full;
  logic              trig_hit;
  logic              rd_fire;
  logic [REC_W-1:0]  rec_in;

  assign rec_in    = {pc_in, instr_in, rf_we_in, rf_waddr_in, rf_wdata_in, mem_we_in};
  assign capturing = (state_q == S_CAPTURE) || (state_q == S_POST);
  // arm and reset both take precedence over a same-cycle commit.
  assign wr_en     = reset && !arm && valid_in && capturing;
  assign at_full   = (count_q == FULL_CNT);
  assign trig_hit  = trig_en_q && (pc_in == trig_pc_q);
  assign rd_valid  = (state_q == S_DONE) && (count_q != '0);
  assign rd_fire   = rd_valid && rd_ready;

  assign rd_data   = mem[rd_ptr];
  assign count     = count_q;
  assign state     = state_q;
  assign triggered = triggered_q;
  assign overflow  = overflow_q;

  // Record storage: written at wr_ptr on every accepted commit.
  // NOTE: the array has no reset on purpose; stale contents are never
  // visible because rd_valid is gated by count, and a reset-free array maps
  // onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= rec_in;
    end
  end

  // Capture/drain controller: pointers, occupancy, trigger and FSM state.
  // NOTE: every register here uses non-blocking assignment so all updates
  // see the pre-edge values, e.g. count and rd_ptr move together on a pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mode_q      <= M_FILL;
      trig_en_q   <= 1'b0;
      trig_pc_q   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      post_cnt    <= '0;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (arm) begin
      mode_q      <= mode_t'(mode);
      trig_en_q   <= trig_en;
      trig_pc_q   <= trig_pc;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      post_cnt    <= '0;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
      state_q     <= S_CAPTURE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
        end

        S_CAPTURE: begin
          if (valid_in) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (!at_full) begin
              count_q <= count_q + 1'b1;
            end else if (mode_q == M_RING) begin
              // Buffer full in RING: the oldest record was just overwritten.
              rd_ptr     <= rd_ptr + 1'b1;
              overflow_q <= 1'b1;
            end
            if (trig_hit) begin
              triggered_q <= 1'b1;
            end
            if (mode_q == M_RING && trig_hit) begin
              if (POST_TRIG == 0) begin
                state_q <= S_DONE;
              end else begin
                post_cnt <= POST_INIT;
                state_q  <= S_POST;
              end
            end else if (mode_q == M_FILL && count_q == LAST_CNT) begin
              state_q <= S_DONE;
            end
          end
        end

        S_POST: begin
          if (valid_in) begin
            wr_ptr   <= wr_ptr + 1'b1;
            post_cnt <= post_cnt - 1'b1;
            if (!at_full) begin
              count_q <= count_q + 1'b1;
            end else begin
              rd_ptr     <= rd_ptr + 1'b1;
              overflow_q <= 1'b1;
            end
            if (post_cnt == AW'(1)) begin
              state_q <= S_DONE;
            end
          end
        end

        S_DONE: begin
          if (rd_fire) begin
            rd_ptr  <= rd_ptr + 1'b1;
            count_q <= count_q - 1'b1;
          end
        end
      endcase
    end
  end

endmodule
